decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, giving the instruction word held while out_valid is low.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: fetch presents in_instr and in_pc.
REQ-005 The block SHALL have port in_ready, output, 1 bit: decode accepts this cycle.
REQ-006 The block SHALL have ports in_instr and in_pc, input, 32 bits each: fetched word and its PC.
REQ-007 The block SHALL have port flush, input, 1 bit: squash the held and incoming instruction.
REQ-008 The block SHALL have port out_valid, output, 1 bit: decoded fields valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream consumes this cycle.
REQ-010 The block SHALL have port out_pc, output, 32 bits: PC of the held instruction.
REQ-011 The block SHALL have ports rs, rt, rd, shamt, output, 5 bits each, and opcode and funct, output, 6 bits each.
REQ-012 The block SHALL have port imm16, output, 16 bits, and port sign_ext, output, 1 bit; both feed the immediate extender.
REQ-013 The block SHALL have ports reg_write, mem_read, mem_write, alu_src, branch, jump, illegal, output, 1 bit each.

Function
REQ-014 The block SHALL be a one-entry pipeline register with in_ready = !out_valid || out_ready, computed combinationally.
REQ-015 The block SHALL capture the input on a clock edge when in_valid && in_ready && !flush; out_valid SHALL then be 1 on the next cycle, giving 1-cycle latency.
REQ-016 When out_valid && out_ready && no capture occurs, out_valid SHALL go to 0 and the held instruction word SHALL become NOP_INSTR.
REQ-017 Simultaneous consume and capture SHALL replace the held entry with no bubble cycle.
REQ-018 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 flush SHALL take priority over capture: the next cycle has out_valid=0 and the incoming word is dropped.
REQ-020 Decoding SHALL be done on in_instr before the register, and the decoded outputs SHALL be registered.
REQ-021 Field mapping SHALL be: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0].
REQ-022 sign_ext SHALL be 1 for opcodes 04 beq, 05 bne, 08 addi, 09 addiu, 0A slti, 0B sltiu, 23 lw, 2B sw.
REQ-023 sign_ext SHALL be 0 for opcodes 0C andi, 0D ori, 0E xori, 0F lui, 00 R-type, and 02 j.
REQ-024 Opcode 00 SHALL decode as reg_write=1, alu_src=0.
REQ-025 I-type ALU opcodes and lw SHALL decode as reg_write=1, alu_src=1; lw SHALL also set mem_read=1.
REQ-026 sw SHALL decode as mem_write=1, alu_src=1.
REQ-027 beq and bne SHALL decode as branch=1.
REQ-028 j SHALL decode as jump=1.
REQ-029 Any other opcode SHALL set illegal=1 with all other controls 0 and out_valid asserted as normal.
REQ-030 When out_valid=0, all control outputs SHALL be 0.

Reset
REQ-031 rst_n low SHALL asynchronously force out_valid=0, out_pc=0, all fields=0, all controls=0, and the held instruction to NOP_INSTR.
REQ-032 Reset mid-transfer SHALL discard the held instruction, with no capture on the first clock edge after deassertion unless in_valid is high.

Structure
REQ-033 Opcode and funct localparams such as OP_RTYPE, OP_LW and OP_BEQ SHALL live in shared package mips_pkg, reused by the ALU control and extender users.
REQ-034 A combinational sub-module ctrl_decode (opcode in, controls plus sign_ext out) SHALL be instantiated, with the pipeline register kept in decode_unit.

Verification
REQ-035 Scenario: reset, then in_instr=32'h2008FFFF (addi) at in_pc=32'h0000_0040 with out_ready=1 -> next cycle out_valid=1, rt=8, imm16=FFFF, sign_ext=1, reg_write=1, alu_src=1, out_pc=0x40.
REQ-036 Scenario: ori 32'h3508_8000 -> sign_ext=0, imm16=8000, reg_write=1.
REQ-037 Scenario: out_ready=0 held 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged; after release, next word captured with no bubble.
REQ-038 Scenario: flush and in_valid high in the same cycle with lw 32'h8C09_0004 -> next cycle out_valid=0 and the lw is never presented.
REQ-039 Scenario: opcode 6'h3F -> illegal=1, reg_write=mem_write=branch=0.
REQ-040 Scenario: rst_n pulled low mid-cycle while out_valid=1 -> out_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct encodings and decode record types.
// Used by the decode stage, ALU control and the immediate extender.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic illegal;
    logic sign_ext;
  } ctrl_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
  } fields_t;

  function automatic fields_t split_instr(input logic [31:0] w);
    fields_t f;
    f.opcode = w[31:26];
    f.rs     = w[25:21];
    f.rt     = w[20:16];
    f.rd     = w[15:11];
    f.shamt  = w[10:6];
    f.funct  = w[5:0];
    f.imm16  = w[15:0];
    return f;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main control: opcode to datapath controls and extender mode.
module ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: ctrl.reg_write = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.sign_ext  = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = 1'b1;
        ctrl.sign_ext = 1'b1;
      end
      OP_J:    ctrl.jump    = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: decodes the fetched word and holds fields/controls in a
// one-entry valid/ready pipeline register.
module decode_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        sign_ext,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  ctrl_t   dec_ctrl;
  ctrl_t   ctrl_q;
  fields_t fields_q;
  logic    valid_q;
  logic    capture;

  ctrl_decode u_ctrl_decode (
    .opcode (in_instr[31:26]),
    .ctrl   (dec_ctrl)
  );

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Controls are zeroed whenever the entry empties, so they are already
  // gated by out_valid without extra output logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      out_pc   <= '0;
      fields_q <= '0;
      ctrl_q   <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      fields_q <= split_instr(NOP_INSTR);
      ctrl_q   <= '0;
    end else if (capture) begin
      valid_q  <= 1'b1;
      out_pc   <= in_pc;
      fields_q <= split_instr(in_instr);
      ctrl_q   <= dec_ctrl;
    end else if (valid_q && out_ready) begin
      valid_q  <= 1'b0;
      fields_q <= split_instr(NOP_INSTR);
      ctrl_q   <= '0;
    end
  end

  assign out_valid = valid_q;
  assign opcode    = fields_q.opcode;
  assign rs        = fields_q.rs;
  assign rt        = fields_q.rt;
  assign rd        = fields_q.rd;
  assign shamt     = fields_q.shamt;
  assign funct     = fields_q.funct;
  assign imm16     = fields_q.imm16;
  assign sign_ext  = ctrl_q.sign_ext;
  assign reg_write = ctrl_q.reg_write;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign alu_src   = ctrl_q.alu_src;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: hand-computed field/control expectations.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic        sign_ext, reg_write, mem_read, mem_write, alu_src;
  logic        branch, jump, illegal;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  decode_unit #(.NOP_INSTR(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .opcode    (opcode),
    .funct     (funct),
    .imm16     (imm16),
    .sign_ext  (sign_ext),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .branch    (branch),
    .jump      (jump),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #12 rst_n = 1'b1;
    step();

    // addi $8,$0,-1
    drive(1'b1, 32'h2008_FFFF, 32'h0000_0040);
    step();
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_rt", {27'd0, rt}, 32'd8);
    check("addi_rs", {27'd0, rs}, 32'd0);
    check("addi_imm", {16'd0, imm16}, 32'h0000_FFFF);
    check("addi_sext", {31'd0, sign_ext}, 32'd1);
    check("addi_regw", {31'd0, reg_write}, 32'd1);
    check("addi_alusrc", {31'd0, alu_src}, 32'd1);
    check("addi_memrd", {31'd0, mem_read}, 32'd0);
    check("addi_pc", out_pc, 32'h0000_0040);

    // ori $8,$8,0x8000 back-to-back
    drive(1'b1, 32'h3508_8000, 32'h0000_0044);
    step();
    check("ori_opcode", {26'd0, opcode}, 32'h0D);
    check("ori_sext", {31'd0, sign_ext}, 32'd0);
    check("ori_imm", {16'd0, imm16}, 32'h0000_8000);
    check("ori_regw", {31'd0, reg_write}, 32'd1);
    check("ori_pc", out_pc, 32'h0000_0044);

    // stall three cycles with sw waiting
    drive(1'b1, 32'hAD2A_0008, 32'h0000_0048);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_opcode", {26'd0, opcode}, 32'h0D);
      check("stall_pc", out_pc, 32'h0000_0044);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("sw_valid", {31'd0, out_valid}, 32'd1);
    check("sw_opcode", {26'd0, opcode}, 32'h2B);
    check("sw_memw", {31'd0, mem_write}, 32'd1);
    check("sw_alusrc", {31'd0, alu_src}, 32'd1);
    check("sw_regw", {31'd0, reg_write}, 32'd0);
    check("sw_sext", {31'd0, sign_ext}, 32'd1);
    check("sw_pc", out_pc, 32'h0000_0048);

    // flush together with lw: lw dropped, entry emptied
    drive(1'b1, 32'h8C09_0004, 32'h0000_004C);
    flush = 1'b1;
    step();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_memrd", {31'd0, mem_read}, 32'd0);
    check("flush_opcode", {26'd0, opcode}, 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("flush_after_valid", {31'd0, out_valid}, 32'd0);
    check("flush_after_memrd", {31'd0, mem_read}, 32'd0);

    // add $10,$8,$9
    drive(1'b1, 32'h0109_5020, 32'h0000_0050);
    step();
    check("add_regw", {31'd0, reg_write}, 32'd1);
    check("add_alusrc", {31'd0, alu_src}, 32'd0);
    check("add_rd", {27'd0, rd}, 32'd10);
    check("add_funct", {26'd0, funct}, 32'h20);
    check("add_sext", {31'd0, sign_ext}, 32'd0);

    // beq $8,$9,3
    drive(1'b1, 32'h1109_0003, 32'h0000_0054);
    step();
    check("beq_branch", {31'd0, branch}, 32'd1);
    check("beq_sext", {31'd0, sign_ext}, 32'd1);
    check("beq_regw", {31'd0, reg_write}, 32'd0);

    // bne $8,$9,2
    drive(1'b1, 32'h1509_0002, 32'h0000_0058);
    step();
    check("bne_branch", {31'd0, branch}, 32'd1);
    check("bne_pc", out_pc, 32'h0000_0058);

    // j 0x10
    drive(1'b1, 32'h0800_0010, 32'h0000_005C);
    step();
    check("j_jump", {31'd0, jump}, 32'd1);
    check("j_sext", {31'd0, sign_ext}, 32'd0);
    check("j_branch", {31'd0, branch}, 32'd0);

    // unknown opcode 0x3F
    drive(1'b1, 32'hFC00_0000, 32'h0000_0060);
    step();
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_illegal", {31'd0, illegal}, 32'd1);
    check("ill_regw", {31'd0, reg_write}, 32'd0);
    check("ill_memw", {31'd0, mem_write}, 32'd0);
    check("ill_branch", {31'd0, branch}, 32'd0);

    // drain without refill
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_illegal", {31'd0, illegal}, 32'd0);
    check("drain_opcode", {26'd0, opcode}, 32'd0);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);

    // lui, then asynchronous reset between edges
    drive(1'b1, 32'h3C0A_1234, 32'h0000_0064);
    step();
    check("lui_regw", {31'd0, reg_write}, 32'd1);
    check("lui_sext", {31'd0, sign_ext}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_regw", {31'd0, reg_write}, 32'd0);
    check("arst_imm", {16'd0, imm16}, 32'd0);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // andi after reset
    drive(1'b1, 32'h3108_FFFF, 32'h0000_0068);
    step();
    check("andi_valid", {31'd0, out_valid}, 32'd1);
    check("andi_sext", {31'd0, sign_ext}, 32'd0);
    check("andi_alusrc", {31'd0, alu_src}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
